// File: rtl/hb_interp_iq.sv
// Half-band x2 interpolator for an I/Q pair: 4-tap (-1,9,9,-1)/16 midpoint filter on even
// phases, delayed-sample pass-through on odd phases, with optional bypass and a rate counter.
module hb_interp_iq #(
  parameter int WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    bypass,
  input  logic [7:0]              cpo,
  output logic                    stb_in,
  input  logic signed [WIDTH-1:0] data_in_i,
  input  logic signed [WIDTH-1:0] data_in_q,
  output logic                    stb_out,
  output logic signed [WIDTH-1:0] data_out_i,
  output logic signed [WIDTH-1:0] data_out_q,
  output logic                    ovf
);

  localparam int ACC_W = WIDTH + 5;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{6{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{6{1'b1}}, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(8);

  function automatic logic signed [ACC_W-1:0] fir_mid(
    input logic signed [WIDTH-1:0] d,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] c
  );
    logic signed [ACC_W-1:0] s;
    s = ACC_W'(a) + ACC_W'(b);
    return ((s <<< 3) + s) - ACC_W'(d) - ACC_W'(c);
  endfunction

  function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] y);
    logic signed [ACC_W-1:0] t;
    t = y + RND_HALF;
    return t >>> 4;
  endfunction

  function automatic logic sat_clip(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX;
    else if (v < SAT_MIN) r = SAT_MIN;
    else                  r = v;
    return r[WIDTH-1:0];
  endfunction

  logic [7:0] cnt;
  logic [7:0] cpo_eff;
  logic [7:0] term;
  logic       phase;
  logic       tick;

  logic signed [WIDTH-1:0] din     [2];
  logic signed [WIDTH-1:0] x0      [2];
  logic signed [WIDTH-1:0] x1      [2];
  logic signed [WIDTH-1:0] x2      [2];
  logic signed [ACC_W-1:0] y_p0    [2];
  logic signed [WIDTH-1:0] mid_p0  [2];
  logic [1:0]              clip_p0;
  logic signed [WIDTH-1:0] dout_p1 [2];

  assign din[0] = data_in_i;
  assign din[1] = data_in_q;

  assign cpo_eff = (cpo < 8'd2) ? 8'd2 : cpo;
  assign term    = cpo_eff - 8'd1;
  assign tick    = enable & ~rst & (cnt >= term);
  assign stb_in  = tick & (bypass | ~phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      phase   <= 1'b0;
      stb_out <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      cnt     <= (!enable || tick) ? 8'd0 : cnt + 8'd1;
      phase   <= (bypass || !enable) ? 1'b0 : (tick ? ~phase : phase);
      stb_out <= tick;
      if (tick && !bypass && !phase && (|clip_p0)) ovf <= 1'b1;
    end
  end

  // p0: midpoint from the pre-shift delay line and the sample being consumed
  always_comb begin
    clip_p0 = '0;
    for (int ch = 0; ch < 2; ch++) begin
      y_p0[ch]    = round_half_up(fir_mid(din[ch], x0[ch], x1[ch], x2[ch]));
      mid_p0[ch]  = saturate(y_p0[ch]);
      clip_p0[ch] = sat_clip(y_p0[ch]);
    end
  end

  // p1: delay line update and registered output sample
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        x0[ch]      <= '0;
        x1[ch]      <= '0;
        x2[ch]      <= '0;
        dout_p1[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (stb_in && !bypass) begin
          x0[ch] <= din[ch];
          x1[ch] <= x0[ch];
          x2[ch] <= x1[ch];
        end
        // Odd phase consumes nothing, so x1 here already holds the post-shift sample.
        if (tick) begin
          if (bypass)      dout_p1[ch] <= din[ch];
          else if (!phase) dout_p1[ch] <= mid_p0[ch];
          else             dout_p1[ch] <= x1[ch];
        end
      end
    end
  end

  assign data_out_i = dout_p1[0];
  assign data_out_q = dout_p1[1];

endmodule
